load_store_unit: RTL and testbench
==================================

# load_store_unit

Byte-serial initiator for the 64-byte, byte-addressed data memory. Accepts one RISC-V load/store request at a time from the MEM stage over a valid/ready handshake and performs it as a sequence of single-byte memory transfers, one per cycle, little-endian. For loads it assembles the bytes and applies RV64 sign or zero extension. It covers all RV64I widths (b/h/w/d, signed and unsigned), reports range and encoding errors, and frees the memory side from multi-byte port logic.

## Interface
- ADDR_WIDTH, 6, memory byte-address width (memory size = 2^ADDR_WIDTH bytes)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE immediately
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu)
- req_addr  in  64  byte address
- req_wdata  in  64  store data (low bytes used)
- resp_valid  out  1  one-cycle pulse, request complete
- resp_error  out  1  qualified by resp_valid; request rejected, no memory access made
- resp_rdata  out  64  load result, qualified by resp_valid; 0 for stores and errors
- mem_addr  out  ADDR_WIDTH  byte address to memory
- mem_we  out  1  byte write strobe, sampled by memory on rising clk
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  combinational read data for mem_addr

## Operation
- States: IDLE, ACCESS, DONE.
- Byte count N from funct3[1:0]: 00→1, 01→2, 10→4, 11→8.
- IDLE: on accept, latch write, funct3, addr, wdata, and clear byte index i and assembly register.
- Error check at accept: the request is an error if funct3 = 111, if it is a store with funct3[2] = 1, or if req_addr + N > 2^ADDR_WIDTH (full 64-bit compare; addresses with any bit ≥ ADDR_WIDTH set are errors). On error go straight to DONE with resp_error = 1. No mem_we is issued.
- Otherwise go to ACCESS.
- ACCESS, per cycle:
  - mem_addr = base + i.
  - Store: mem_we = 1, mem_wdata = wdata[8i+7:8i].
  - Load: mem_we = 0, and mem_rdata is captured into byte i of the assembly register at the clock edge.
  - i increments. After i = N−1, go to DONE.
- Load extension: unsigned if funct3[2] = 1; otherwise bit 8N−1 is replicated into the upper bits. Applied when the result is registered into resp_rdata on the ACCESS→DONE edge.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata and resp_error hold until the next DONE.
- Outside ACCESS: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Requests are never queued. req_valid while req_ready = 0 is ignored, and the requester must hold it.

## Timing
- Reset values: state IDLE, req_ready 1 (requests ignored while reset is high), resp_valid 0, resp_error 0, resp_rdata 0, mem_we 0, mem_addr 0, mem_wdata 0, i 0.
- Accept at edge T0. Byte k is transferred in cycle T0+1+k. resp_valid is high in cycle T0+N+1. req_ready is high again in cycle T0+N+2.
- Latency to response: 2 cycles for byte, 3 for half, 5 for word, 9 for double. Error response comes 1 cycle after accept.
- Back-to-back throughput is N+2 cycles per request.
- Reset mid-ACCESS aborts immediately with no response. Bytes already written stay written, so a partial store is permitted.
- Loads depend on mem_rdata being combinational, valid in the same cycle as mem_addr.

## Test plan
- Memory bytes 0..7 = 02 04 08 0c 0e 22 44 88; ld (011) at 0 → resp_valid 9 cycles after accept, rdata 0x8844220E0C080402, error 0.
- lb (000) at 7 → 0xFFFFFFFFFFFFFF88 after 2 cycles; lbu (100) at 7 → 0x0000000000000088; lhu (101) at 6 → 0x0000000000008844.
- sw (010) wdata 0x12345678DEADBEEF at 16 → mem_we high exactly 4 cycles with bytes EF BE AD DE at addresses 16..19. A following lw at 16 → 0xFFFFFFFFDEADBEEF; lwu → 0x00000000DEADBEEF. Byte 20 unchanged.
- Error cases, each responding 1 cycle after accept with error 1, rdata 0, and mem_we never high:
  - ld at 60 (range)
  - sb at 64 (range)
  - funct3 111 load
  - store with funct3 100
- Back-to-back: req_valid held high with two lb requests → second accepted exactly 3 cycles after first, req_ready low in between.
- Assert reset in the 3rd cycle of an sd at 8 → all outputs return to reset values immediately, no resp_valid. Only bytes 8 and 9 are modified. The next request completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and byte-memory signals of the load/store unit.
// The slave modport is the LSU; the master modport is the MEM stage together with the memory.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [63:0]           req_addr;
  logic [63:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_error;
  logic [63:0]           resp_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_error, resp_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_error, resp_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte-serial RV64 load/store initiator: one byte per cycle, little-endian,
// with sign/zero extension of loads and up-front range/encoding checks.
module load_store_unit #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [2:0]            idx_q, idx_d;
  logic [63:0]           asm_q, asm_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic                  req_err;
  logic [2:0]            last_idx;

  function automatic logic [3:0] byte_count(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] v, input logic [2:0] f3);
    logic fill;
    fill = 1'b0;
    case (f3[1:0])
      2'b00:   begin fill = v[7]  & ~f3[2]; return {{56{fill}}, v[7:0]};  end
      2'b01:   begin fill = v[15] & ~f3[2]; return {{48{fill}}, v[15:0]}; end
      2'b10:   begin fill = v[31] & ~f3[2]; return {{32{fill}}, v[31:0]}; end
      default: return v;
    endcase
  endfunction

  // Full 65-bit compare so any address bit above the memory range flags an error.
  always_comb begin
    req_err = (bus.req_funct3 == 3'b111) ||
              (bus.req_write && bus.req_funct3[2]) ||
              (({1'b0, bus.req_addr} + 65'(byte_count(bus.req_funct3[1:0]))) >
               (65'd1 << ADDR_WIDTH));
    last_idx = 3'(byte_count(funct3_q[1:0]) - 4'd1);
  end

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    idx_d          = idx_q;
    asm_d          = asm_q;
    rdata_d        = rdata_q;
    error_d        = error_q;
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE);
    bus.resp_error = error_q;
    bus.resp_rdata = rdata_q;
    bus.mem_addr   = '0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr[ADDR_WIDTH-1:0];
          wdata_d  = bus.req_wdata;
          idx_d    = 3'd0;
          asm_d    = 64'd0;
          if (req_err) begin
            state_d = DONE;
            error_d = 1'b1;
            rdata_d = 64'd0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        bus.mem_addr = addr_q + ADDR_WIDTH'(idx_q);
        if (write_q) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
        end else begin
          asm_d[{idx_q, 3'b000} +: 8] = bus.mem_rdata;
        end
        idx_d = idx_q + 3'd1;
        // The final byte is folded in combinationally so extension sees the whole value.
        if (idx_q == last_idx) begin
          state_d = DONE;
          error_d = 1'b0;
          rdata_d = write_q ? 64'd0 : extend_load(asm_d, funct3_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      rdata_q <= 64'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    write_q  <= write_d;
    funct3_q <= funct3_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    asm_q    <= asm_d;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests
// checked against a byte-array memory model.
module tb_load_store_unit;
  localparam int AW  = 6;
  localparam int MSZ = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();
  load_store_unit #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0]    mem     [MSZ];
  logic [7:0]    ref_mem [MSZ];
  logic          tb_wr = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [7:0]    tb_wd = 8'h00;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (tb_wr) mem[tb_wa] <= tb_wd;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0;
  end

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Little-endian value of N bytes, then two's-complement reinterpretation for signed loads.
  function automatic logic [63:0] model_load(input int unsigned a, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = nbytes(f3);
    v = 64'd0;
    for (int k = 0; k < n; k++) v = v + (64'(ref_mem[a + k]) << (8 * k));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic model_err(input logic w, input logic [2:0] f3, input logic [63:0] a);
    return (f3 == 3'b111) || (w && f3[2]) || (a > 64'(MSZ - nbytes(f3)));
  endfunction

  task automatic write_byte(input int a, input logic [7:0] d);
    @(negedge clk);
    tb_wr = 1'b1; tb_wa = AW'(a); tb_wd = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 tb_wr = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er,
                        output int lat, output int wes);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    lat = 0; wes = 0; rd = 64'hx; er = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.mem_we) wes++;
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; er = bus.resp_error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); else pass_cnt++;
    total_cnt++; if (bus.resp_error !== 1'b0) $display("FAIL reset_resp_error: got %b expected 0", bus.resp_error); else pass_cnt++;
    total_cnt++; if (bus.resp_rdata !== 64'd0) $display("FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); else pass_cnt++;
    total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== '0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_preload();
    logic [7:0] init8 [8];
    init8 = '{8'h02, 8'h04, 8'h08, 8'h0c, 8'h0e, 8'h22, 8'h44, 8'h88};
    for (int a = 0; a < MSZ; a++) write_byte(a, (a < 8) ? init8[a] : 8'($urandom));
  endtask

  task automatic test_spec_loads();
    logic [2:0]  f3s  [4];
    int          adrs [4];
    logic [63:0] exps [4];
    int          lats [4];
    logic [63:0] rd; logic er; int lat, wes;
    f3s  = '{3'b011, 3'b000, 3'b100, 3'b101};
    adrs = '{0, 7, 7, 6};
    exps = '{64'h8844220E0C080402, 64'hFFFFFFFFFFFFFF88, 64'h0000000000000088, 64'h0000000000008844};
    lats = '{9, 2, 2, 3};
    for (int t = 0; t < 4; t++) begin
      do_req(1'b0, f3s[t], 64'(adrs[t]), 64'd0, rd, er, lat, wes);
      total_cnt++; if (rd !== exps[t]) $display("FAIL load%0d_rdata: got %h expected %h", t, rd, exps[t]); else pass_cnt++;
      total_cnt++; if (lat !== lats[t]) $display("FAIL load%0d_latency: got %0d expected %0d", t, lat, lats[t]); else pass_cnt++;
      total_cnt++; if (er !== 1'b0) $display("FAIL load%0d_error: got %b expected 0", t, er); else pass_cnt++;
    end
  endtask

  task automatic test_store_word();
    logic [63:0] rd; logic er; int lat, wes;
    logic [7:0] b20;
    b20 = ref_mem[20];
    do_req(1'b1, 3'b010, 64'd16, 64'h12345678DEADBEEF, rd, er, lat, wes);
    total_cnt++; if (wes !== 4) $display("FAIL sw_we_cycles: got %0d expected 4", wes); else pass_cnt++;
    total_cnt++; if (lat !== 5) $display("FAIL sw_latency: got %0d expected 5", lat); else pass_cnt++;
    total_cnt++; if ({er, rd} !== 65'd0) $display("FAIL sw_resp: got err=%b rdata=%h expected 0/0", er, rd); else pass_cnt++;
    total_cnt++; if ({mem[19], mem[18], mem[17], mem[16]} !== 32'hDEADBEEF)
      $display("FAIL sw_bytes: got %h expected deadbeef", {mem[19], mem[18], mem[17], mem[16]}); else pass_cnt++;
    total_cnt++; if (mem[20] !== b20) $display("FAIL sw_byte20: got %h expected %h", mem[20], b20); else pass_cnt++;
    ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;
    do_req(1'b0, 3'b010, 64'd16, 64'd0, rd, er, lat, wes);
    total_cnt++; if (rd !== 64'hFFFFFFFFDEADBEEF) $display("FAIL lw_rdata: got %h expected ffffffffdeadbeef", rd); else pass_cnt++;
    do_req(1'b0, 3'b110, 64'd16, 64'd0, rd, er, lat, wes);
    total_cnt++; if (rd !== 64'h00000000DEADBEEF) $display("FAIL lwu_rdata: got %h expected 00000000deadbeef", rd); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic        ws   [4];
    logic [2:0]  f3s  [4];
    logic [63:0] adrs [4];
    logic [63:0] rd; logic er; int lat, wes;
    ws   = '{1'b0, 1'b1, 1'b0, 1'b1};
    f3s  = '{3'b011, 3'b000, 3'b111, 3'b100};
    adrs = '{64'd60, 64'd64, 64'd0, 64'd0};
    for (int t = 0; t < 4; t++) begin
      do_req(ws[t], f3s[t], adrs[t], 64'hA5A5A5A5A5A5A5A5, rd, er, lat, wes);
      total_cnt++; if (er !== 1'b1) $display("FAIL err%0d_flag: got %b expected 1", t, er); else pass_cnt++;
      total_cnt++; if (rd !== 64'd0) $display("FAIL err%0d_rdata: got %h expected 0", t, rd); else pass_cnt++;
      total_cnt++; if (lat !== 1) $display("FAIL err%0d_latency: got %0d expected 1", t, lat); else pass_cnt++;
      total_cnt++; if (wes !== 0) $display("FAIL err%0d_we: got %0d expected 0", t, wes); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic w; logic [2:0] f3; logic [63:0] a, wd, rd, exp_rd; logic er, exp_er;
    int lat, wes, n, bad;
    for (int it = 0; it < 60; it++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 66));
      wd = {32'($urandom), 32'($urandom)};
      n  = nbytes(f3);
      exp_er = model_err(w, f3, a);
      exp_rd = (!exp_er && !w) ? model_load(int'(a), f3) : 64'd0;
      do_req(w, f3, a, wd, rd, er, lat, wes);
      if (!exp_er && w) for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
      total_cnt++; if (er !== exp_er) $display("FAIL rnd%0d_error: got %b expected %b", it, er, exp_er); else pass_cnt++;
      total_cnt++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata: got %h expected %h", it, rd, exp_rd); else pass_cnt++;
      total_cnt++; if (lat !== (exp_er ? 1 : n + 1)) $display("FAIL rnd%0d_latency: got %0d expected %0d", it, lat, exp_er ? 1 : n + 1); else pass_cnt++;
      total_cnt++; if (wes !== ((!exp_er && w) ? n : 0)) $display("FAIL rnd%0d_we: got %0d expected %0d", it, wes, (!exp_er && w) ? n : 0); else pass_cnt++;
    end
    bad = 0;
    for (int k = 0; k < MSZ; k++) if (mem[k] !== ref_mem[k]) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL rnd_memory: got %0d differing bytes expected 0", bad); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int gap, lat_b;
    logic [63:0] rd_a, rd_b, exp_a, exp_b;
    exp_a = model_load(1, 3'b000);
    exp_b = model_load(2, 3'b000);
    rd_a = 64'hx; rd_b = 64'hx; gap = 0; lat_b = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b000; bus.req_addr = 64'd1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_addr = 64'd2;
      if (bus.resp_valid) rd_a = bus.resp_rdata;
      if (bus.req_ready) begin gap = k; break; end
    end
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin rd_b = bus.resp_rdata; lat_b = c; break; end
    end
    total_cnt++; if (gap !== 3) $display("FAIL b2b_gap: got %0d expected 3", gap); else pass_cnt++;
    total_cnt++; if (rd_a !== exp_a) $display("FAIL b2b_first_rdata: got %h expected %h", rd_a, exp_a); else pass_cnt++;
    total_cnt++; if (rd_b !== exp_b) $display("FAIL b2b_second_rdata: got %h expected %h", rd_b, exp_b); else pass_cnt++;
    total_cnt++; if (lat_b !== 2) $display("FAIL b2b_second_latency: got %0d expected 2", lat_b); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    logic [63:0] wd, rd; logic er; int lat, wes;
    logic [7:0] keep [6];
    logic saw_valid;
    int bad;
    wd = {32'($urandom), 32'($urandom)};
    for (int k = 0; k < 6; k++) keep[k] = ref_mem[10 + k];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b011;
    bus.req_addr = 64'd8; bus.req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
    end
    total_cnt++; if (bus.mem_we !== 1'b1) $display("FAIL rst_mid_we_before: got %b expected 1", bus.mem_we); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mid_mem_we: got %b expected 0", bus.mem_we); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== '0) $display("FAIL rst_mid_mem_addr: got %h expected 0", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_wdata !== 8'h00) $display("FAIL rst_mid_mem_wdata: got %h expected 0", bus.mem_wdata); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.resp_rdata !== 64'd0) $display("FAIL rst_mid_rdata: got %h expected 0", bus.resp_rdata); else pass_cnt++;
    saw_valid = bus.resp_valid;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) reset = 1'b0;
      saw_valid = saw_valid | bus.resp_valid;
    end
    total_cnt++; if (saw_valid !== 1'b0) $display("FAIL rst_mid_no_resp: got %b expected 0", saw_valid); else pass_cnt++;
    total_cnt++; if ({mem[9], mem[8]} !== wd[15:0]) $display("FAIL rst_mid_bytes_8_9: got %h expected %h", {mem[9], mem[8]}, wd[15:0]); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 6; k++) if (mem[10 + k] !== keep[k]) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL rst_mid_untouched: got %0d changed bytes expected 0", bad); else pass_cnt++;
    ref_mem[8] = wd[7:0]; ref_mem[9] = wd[15:8];
    do_req(1'b0, 3'b011, 64'd8, 64'd0, rd, er, lat, wes);
    total_cnt++; if (rd !== model_load(8, 3'b011)) $display("FAIL post_rst_rdata: got %h expected %h", rd, model_load(8, 3'b011)); else pass_cnt++;
    total_cnt++; if (lat !== 9) $display("FAIL post_rst_latency: got %0d expected 9", lat); else pass_cnt++;
    total_cnt++; if (er !== 1'b0) $display("FAIL post_rst_error: got %b expected 0", er); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_spec_loads();
    test_store_word();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
